// File: rtl/keymon_pkg.sv
// Shared types and default parameters for the key sequence monitor.
// Holds the 2-bit FSM state encoding used on state_o.
package keymon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ALERT = 2'd2
   } state_e;

   localparam int DefKeyWidth     = 128;
   localparam int DefNumPat       = 4;
   localparam int DefCntWidth     = 9;
   localparam int DefThreshold    = 257;
   localparam int DefWindowCycles = 64;

endpackage

// File: rtl/key_match_ctr.sv
// One trigger slot: pattern register, key comparator and saturating match counter.
// hit_o looks at the next counter value so the parent can register the alert in the strobe cycle.
module key_match_ctr
   import keymon_pkg::*;
#(
   parameter int KeyWidth  = DefKeyWidth,
   parameter int CntWidth  = DefCntWidth,
   parameter int Threshold = DefThreshold
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                pat_we_i,
   input  logic [KeyWidth-1:0] pat_i,
   input  logic                en_i,
   input  logic                strobe_i,
   input  logic [KeyWidth-1:0] key_i,
   input  logic                clr_i,
   output logic [CntWidth-1:0] cnt_o,
   output logic                hit_o
);

   localparam logic [CntWidth-1:0] ThrCnt = CntWidth'(Threshold);

   logic [KeyWidth-1:0] pat_q;
   logic [CntWidth-1:0] cnt_q;
   logic [CntWidth-1:0] cnt_d;

   // Zeroing (clear, pattern rewrite, disable) outranks a same-cycle strobe.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || pat_we_i || !en_i) begin
         cnt_d = '0;
      end else if (strobe_i) begin
         if (pat_q == key_i) begin
            if (cnt_q < ThrCnt) cnt_d = cnt_q + 1'b1;
         end else begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pat_q <= '0;
         cnt_q <= '0;
      end else begin
         if (pat_we_i) pat_q <= pat_i;
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign hit_o = (cnt_d == ThrCnt);

endmodule

// File: rtl/key_seq_monitor.sv
// Watches sideloaded keys for repeated matches against programmable patterns and
// latches an alert once any pattern matches Threshold strobes in a row.
module key_seq_monitor
   import keymon_pkg::*;
#(
   parameter int KeyWidth     = DefKeyWidth,
   parameter int NumPat       = DefNumPat,
   parameter int CntWidth     = DefCntWidth,
   parameter int Threshold    = DefThreshold,
   parameter int WindowCycles = DefWindowCycles,
   localparam int IdxW        = (NumPat > 1) ? $clog2(NumPat) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cfg_we_i,
   input  logic [IdxW-1:0]     cfg_idx_i,
   input  logic [KeyWidth-1:0] cfg_pat_i,
   input  logic [NumPat-1:0]   cfg_en_i,
   input  logic                key_valid_i,
   input  logic [KeyWidth-1:0] key_i,
   input  logic                clear_i,
   output logic                alert_o,
   output logic [IdxW-1:0]     alert_idx_o,
   output logic [CntWidth-1:0] max_cnt_o,
   output logic [1:0]          state_o
);

   localparam int IdleW = $clog2(WindowCycles + 1);
   localparam logic [IdleW-1:0] IdleLast = IdleW'(WindowCycles - 1);

   if (Threshold < 1 || Threshold > (2 ** CntWidth) - 1) begin : g_bad_threshold
      $error("key_seq_monitor: Threshold out of range for CntWidth");
   end
   if (NumPat < 1 || NumPat > 16) begin : g_bad_numpat
      $error("key_seq_monitor: NumPat must be 1..16");
   end

   state_e              state_q, state_d;
   logic                alert_q, alert_d;
   logic [IdxW-1:0]     idx_q, idx_d, hit_idx;
   logic [IdleW-1:0]    idle_q, idle_d;
   logic [NumPat-1:0]   hit, nz;
   logic [CntWidth-1:0] cnt [NumPat];
   logic [CntWidth-1:0] max_cnt;
   logic                strobe, timeout, ctr_clr, any_hit, any_nz;

   assign strobe  = key_valid_i && (state_q != ST_ALERT) && !clear_i;
   assign timeout = (state_q == ST_TRACK) && !key_valid_i && (idle_q == IdleLast);
   assign ctr_clr = clear_i || timeout;

   for (genvar g = 0; g < NumPat; g++) begin : g_pat
      key_match_ctr #(
         .KeyWidth  (KeyWidth),
         .CntWidth  (CntWidth),
         .Threshold (Threshold)
      ) u_ctr (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .pat_we_i (cfg_we_i && (cfg_idx_i == IdxW'(g))),
         .pat_i    (cfg_pat_i),
         .en_i     (cfg_en_i[g]),
         .strobe_i (strobe),
         .key_i    (key_i),
         .clr_i    (ctr_clr),
         .cnt_o    (cnt[g]),
         .hit_o    (hit[g])
      );
      assign nz[g] = |cnt[g];
   end

   assign any_hit = |hit;
   assign any_nz  = |nz;

   // Descending scan so the lowest hitting index is the one left standing.
   always_comb begin
      hit_idx = '0;
      for (int i = NumPat - 1; i >= 0; i--) begin
         if (hit[i]) hit_idx = IdxW'(i);
      end
   end

   always_comb begin
      max_cnt = '0;
      for (int i = 0; i < NumPat; i++) begin
         if (cnt[i] > max_cnt) max_cnt = cnt[i];
      end
   end

   always_comb begin
      idle_d = '0;
      if (!clear_i && (state_q == ST_TRACK) && !key_valid_i && !timeout) begin
         idle_d = idle_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      alert_d = alert_q;
      idx_d   = idx_q;
      if (clear_i) begin
         state_d = ST_IDLE;
         alert_d = 1'b0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (any_hit) begin
                  state_d = ST_ALERT;
                  alert_d = 1'b1;
                  idx_d   = hit_idx;
               end else if (any_nz) begin
                  state_d = ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (any_hit) begin
                  state_d = ST_ALERT;
                  alert_d = 1'b1;
                  idx_d   = hit_idx;
               end else if (timeout || !any_nz) begin
                  state_d = ST_IDLE;
               end
            end
            ST_ALERT: state_d = ST_ALERT;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         alert_q <= 1'b0;
         idx_q   <= '0;
         idle_q  <= '0;
      end else begin
         state_q <= state_d;
         alert_q <= alert_d;
         idx_q   <= idx_d;
         idle_q  <= idle_d;
      end
   end

   assign alert_o     = alert_q;
   assign alert_idx_o = idx_q;
   assign max_cnt_o   = max_cnt;
   assign state_o     = state_q;

endmodule
